// File: rtl/ram_dp_clr.sv
// Simple-dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write policy, optional output register and a clear sequencer
// that sweeps every word to INIT_VAL after reset and on request.
module ram_dp_clr #(
   parameter int unsigned       DATA_W   = 16,
   parameter int unsigned       ADDR_W   = 4,
   parameter logic [DATA_W-1:0] INIT_VAL = '0,
   parameter int unsigned       RDW_MODE = 0,
   parameter int unsigned       OUT_REG  = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   input  logic                clr_req,
   output logic                busy,
   output logic                wr_drop
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned NB    = DATA_W / 8;

   typedef enum logic {StClear, StIdle} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              host_wr, host_rd;
   logic [DATA_W-1:0] rd_word;
   logic [DATA_W-1:0] r1_data_q;
   logic              r1_valid_q;
   logic              wr_drop_q;

   // Busy is the decoded state register, so it changes only on clock or reset.
   assign busy    = (state_q == StClear);
   assign host_wr = wr_en & ~busy;
   assign host_rd = rd_en & ~busy;
   assign wr_drop = wr_drop_q;

   // State and sweep counter register; reset starts a full sweep.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StClear;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   // Next-state logic: sweep to the last address, then idle until clr_req.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         StClear: begin
            if (clr_cnt_q == '1) begin
               state_d   = StIdle;
               clr_cnt_d = '0;
            end else begin
               clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            end
         end
         StIdle: begin
            if (clr_req) begin
               state_d   = StClear;
               clr_cnt_d = '0;
            end
         end
         default: state_d = StClear;
      endcase
   end

   // Array write: the sweep owns the array while busy, otherwise host bytes.
   always_ff @(posedge clk) begin
      if (busy) begin
         mem[clr_cnt_q] <= INIT_VAL;
      end else if (host_wr) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
         end
      end
   end

   // Read word with optional forwarding of enabled bytes of a same-address write.
   always_comb begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == 1 && host_wr && (wr_addr == rd_addr)) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) rd_word[8*k +: 8] = wr_data[8*k +: 8];
         end
      end
   end

   // First read stage and write-drop flag; data holds between reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_data_q  <= '0;
         r1_valid_q <= 1'b0;
         wr_drop_q  <= 1'b0;
      end else begin
         r1_valid_q <= host_rd;
         wr_drop_q  <= wr_en & busy;
         if (host_rd) r1_data_q <= rd_word;
      end
   end

   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r2_data_q;
      logic              r2_valid_q;

      // Optional output pipeline stage; only loads on a valid first-stage result.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r2_data_q  <= '0;
            r2_valid_q <= 1'b0;
         end else begin
            r2_valid_q <= r1_valid_q;
            if (r1_valid_q) r2_data_q <= r1_data_q;
         end
      end

      assign rd_data  = r2_data_q;
      assign rd_valid = r2_valid_q;
   end else begin : g_no_out_reg
      assign rd_data  = r1_data_q;
      assign rd_valid = r1_valid_q;
   end

endmodule

// File: tb/tb_ram_dp_clr.sv
// Bench for ram_dp_clr: two instances share stimulus (A: old-data, latency 1;
// B: merged-data, latency 2). Expected reads are queued with their due cycle
// and checked by a monitor whenever rd_valid is seen.
module tb_ram_dp_clr;

   typedef struct {
      logic [15:0] data;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en, rd_en, clr_req;
   logic [3:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;
   logic [1:0]  wr_be;
   logic [15:0] rd_data_a, rd_data_b;
   logic        rd_valid_a, rd_valid_b, busy_a, busy_b, wr_drop_a, wr_drop_b;

   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        qa[$];
   exp_t        qb[$];
   logic [15:0] m [16];

   ram_dp_clr #(
      .DATA_W(16), .ADDR_W(4), .INIT_VAL(16'hA5A5), .RDW_MODE(0), .OUT_REG(0)
   ) dut_a (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .clr_req(clr_req), .busy(busy_a), .wr_drop(wr_drop_a)
   );

   ram_dp_clr #(
      .DATA_W(16), .ADDR_W(4), .INIT_VAL(16'hA5A5), .RDW_MODE(1), .OUT_REG(1)
   ) dut_b (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .clr_req(clr_req), .busy(busy_b), .wr_drop(wr_drop_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] be);
      logic [15:0] r;
      r = old;
      if (be[0]) r[7:0] = d[7:0];
      if (be[1]) r[15:8] = d[15:8];
      return r;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Inputs are driven at a negedge; the read is sampled at the next posedge.
   task automatic set_read(input logic [3:0] a, input logic [15:0] ea, input logic [15:0] eb);
      exp_t e;
      rd_en   = 1'b1;
      rd_addr = a;
      e.data = ea; e.due = cyc + 1; qa.push_back(e);
      e.data = eb; e.due = cyc + 2; qb.push_back(e);
   endtask

   task automatic set_read_m(input logic [3:0] a);
      set_read(a, m[a], m[a]);
   endtask

   task automatic set_write(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      wr_be   = be;
      m[a]    = merge(m[a], d, be);
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
   endtask

   task automatic count_busy(output int n);
      n = 0;
      while (busy_a && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic read_all_init();
      for (int a = 0; a < 16; a++) begin
         set_read(4'(a), 16'hA5A5, 16'hA5A5);
         tick();
      end
      rd_en = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " rd_data_a"}, 32'(rd_data_a), 32'h0);
      check({tag, " rd_data_b"}, 32'(rd_data_b), 32'h0);
      check({tag, " rd_valid_a"}, 32'(rd_valid_a), 32'h0);
      check({tag, " rd_valid_b"}, 32'(rd_valid_b), 32'h0);
      check({tag, " wr_drop_a"}, 32'(wr_drop_a), 32'h0);
      check({tag, " busy_a"}, 32'(busy_a), 32'h1);
      check({tag, " busy_b"}, 32'(busy_b), 32'h1);
   endtask

   task automatic monitor();
      exp_t e;
      if (rd_valid_a) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_valid_a unexpected: got 1, expected 0 (cycle %0d)", cyc);
         end else begin
            e = qa.pop_front();
            check("rd_data_a", 32'(rd_data_a), 32'(e.data));
            check("rd_cycle_a", 32'(cyc), 32'(e.due));
         end
      end
      if (rd_valid_b) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL rd_valid_b unexpected: got 1, expected 0 (cycle %0d)", cyc);
         end else begin
            e = qb.pop_front();
            check("rd_data_b", 32'(rd_data_b), 32'(e.data));
            check("rd_cycle_b", 32'(cyc), 32'(e.due));
         end
      end
   endtask

   initial begin
      int n;
      logic drop;

      fork
         forever begin
            @(negedge clk);
            monitor();
         end
      join_none

      rst_n = 1'b1;
      idle_inputs();
      wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
      #1 rst_n = 1'b0;
      @(negedge clk);
      tick();
      check_reset_outputs("reset");

      // Reset sweep
      rst_n = 1'b1;
      count_busy(n);
      check("reset sweep length", 32'(n), 32'd16);
      check("busy_b after sweep", 32'(busy_b), 32'h0);
      for (int a = 0; a < 16; a++) m[a] = 16'hA5A5;
      read_all_init();

      // Fill and back-to-back readback
      for (int a = 0; a < 16; a++) begin
         set_write(4'(a), 16'(a * 16'h0101), 2'b11);
         tick();
      end
      wr_en = 1'b0;
      for (int a = 0; a < 16; a++) begin
         set_read_m(4'(a));
         tick();
      end
      rd_en = 1'b0;

      // Byte enables, then read on the very next edge
      set_write(4'd3, 16'h1234, 2'b11); tick();
      set_write(4'd3, 16'hABCD, 2'b01); tick();
      wr_en = 1'b0;
      set_read(4'd3, 16'h12CD, 16'h12CD); tick();
      rd_en = 1'b0;

      // Read-during-write, same address
      set_write(4'd5, 16'h0000, 2'b11); tick();
      set_read(4'd5, 16'h0000, 16'hBE00);
      set_write(4'd5, 16'hBEEF, 2'b10); tick();
      wr_en = 1'b0;
      set_read(4'd5, 16'hBE00, 16'hBE00); tick();
      // Different addresses in the same cycle do not interact
      set_read(4'd7, 16'h0707, 16'h0707);
      set_write(4'd6, 16'h9999, 2'b11); tick();
      set_read(4'd6, 16'h9999, 16'h9999); tick();
      idle_inputs();
      tick();

      // Clear request with simultaneous write and read of address 2
      clr_req = 1'b1;
      set_read(4'd2, 16'h0202, 16'h7777);
      set_write(4'd2, 16'h7777, 2'b11);
      tick();
      check("busy after clr_req", 32'(busy_a), 32'h1);
      n = 0;
      while (busy_a && n < 40) begin
         n++;
         drop = (n == 10);
         wr_en = drop; rd_en = drop; clr_req = drop;
         wr_addr = 4'd0; wr_data = 16'h1111; wr_be = 2'b11; rd_addr = 4'd0;
         tick();
         if (drop) begin
            check("wr_drop_a pulse", 32'(wr_drop_a), 32'h1);
            check("wr_drop_b pulse", 32'(wr_drop_b), 32'h1);
         end
      end
      idle_inputs();
      check("clear sweep length", 32'(n), 32'd16);
      check("wr_drop_a cleared", 32'(wr_drop_a), 32'h0);
      for (int a = 0; a < 16; a++) m[a] = 16'hA5A5;
      read_all_init();
      tick();

      // Reset in the middle of a sweep
      set_write(4'd9, 16'h4242, 2'b11); tick();
      wr_en = 1'b0;
      set_read(4'd9, 16'h4242, 16'h4242); tick();
      rd_en = 1'b0;
      tick();
      clr_req = 1'b1; tick();
      clr_req = 1'b0;
      repeat (6) tick();
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("mid-sweep reset");
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("sweep after mid-sweep reset", 32'(n), 32'd16);

      // Reset with a read in flight in the registered-output instance
      set_read(4'd9, 16'hA5A5, 16'hA5A5); tick();
      rd_en = 1'b0;
      #2 rst_n = 1'b0;
      qb.delete();
      #1 check_reset_outputs("mid-read reset");
      @(negedge clk);
      tick();
      rst_n = 1'b1;
      count_busy(n);
      check("sweep after mid-read reset", 32'(n), 32'd16);
      for (int a = 0; a < 4; a++) begin
         set_read(4'(a), 16'hA5A5, 16'hA5A5);
         tick();
      end
      rd_en = 1'b0;

      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 10) begin
         n++;
         tick();
      end
      check("queue a drained", 32'(qa.size()), 32'd0);
      check("queue b drained", 32'(qb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_dp_clr.md
# ram_dp_clr

Parametrised simple-dual-port synchronous RAM, successor to the team's 16x8 single-port RAM. It has separate write and read ports, per-byte write enables, and a selectable read-during-write policy. An optional output register is provided. A built-in clear sequencer sweeps every location to a programmable value after reset and on request. It is the general-purpose on-chip storage block for buffers and lookup tables in the datapath.

## Interface
- DATA_W, 16, word width in bits; must be a multiple of 8.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words.
- INIT_VAL, 0, DATA_W-bit value written by the clear sweep.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data.
- OUT_REG, 0, 1 adds an output pipeline register (read latency 2 instead of 1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- wr_be  in  DATA_W/8  byte enables; bit k covers wr_data[8k+7:8k].
- rd_en  in  1  read request.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  read data; holds its value between reads.
- rd_valid  out  1  one-cycle pulse, rd_data valid.
- clr_req  in  1  start a clear sweep (level-sampled).
- busy  out  1  clear sweep in progress; host accesses are dropped.
- wr_drop  out  1  one-cycle pulse: a wr_en was ignored because busy was high.

## Operation
- FSM states: CLEAR, IDLE. Reset forces the state to CLEAR with clr_cnt = 0.
- CLEAR state, on each edge:
  - write mem[clr_cnt] <= INIT_VAL.
  - if clr_cnt == DEPTH-1, go to IDLE; otherwise clr_cnt increments.
- IDLE state: clr_req = 1 at an edge moves the FSM to CLEAR with clr_cnt = 0.
- busy is registered and equals (state == CLEAR).
- Write (IDLE, wr_en = 1): for each k with wr_be[k] = 1, mem[wr_addr] byte k <= wr_data byte k. Other bytes keep their value. wr_be = 0 is a legal no-op.
- Read (IDLE, rd_en = 1): captures mem[rd_addr].
- Read-during-write at the same address in the same cycle:
  - RDW_MODE = 0: return the pre-write word.
  - RDW_MODE = 1: return the merged word (enabled bytes from wr_data, other bytes from the array).
  - Different addresses: no interaction.
- While busy:
  - wr_en is dropped, and wr_drop pulses in the following cycle.
  - rd_en is dropped; no rd_valid is generated.
  - clr_req is ignored; the sweep is not restarted.
- In IDLE, wr_en, rd_en and clr_req all at the same edge: the write and the read are both performed at that edge, and CLEAR starts at the next cycle.
- The memory array itself is not reset; the sweep after reset release gives it defined contents.

## Timing
- Reset values:
  - rd_data = 0, rd_valid = 0, wr_drop = 0.
  - busy = 1, state = CLEAR, clr_cnt = 0.
  - The OUT_REG pipeline stage resets to 0/invalid.
- Sweep duration: busy stays high for exactly DEPTH rising edges after rst_n is released (16 for the defaults). It falls after the edge that writes address DEPTH-1. The first host access is accepted at the next edge.
- clr_req in IDLE at edge N: busy = 1 after N; it drops after edge N+DEPTH.
- Read latency, for rd_en sampled at edge N:
  - OUT_REG = 0: rd_data and rd_valid update after edge N.
  - OUT_REG = 1: they update after edge N+1.
- Back-to-back reads are fully pipelined: one result per cycle.
- Write-to-read, different cycles: a write at edge N is visible to a read sampled at edge N+1.
- Reset mid-operation: all in-flight read results are discarded, no rd_valid is issued, and a full sweep restarts.

## Test plan
- Reset sweep, INIT_VAL = 16'hA5A5: release rst_n -> busy high for 16 cycles. Then read addresses 0..15 -> each returns 16'hA5A5 with rd_valid 1 cycle after rd_en (2 cycles with OUT_REG = 1).
- Fill and readback: write data = addr*16'h0101 to addresses 0..15, then read 0..15 back to back -> 16 consecutive rd_valid pulses with matching data, no gaps.
- Byte enables: write 16'h1234 to address 3 with be = 2'b11, then 16'hABCD with be = 2'b01 -> read of address 3 returns 16'h12CD.
- Read-during-write: address 5 holds 16'h0000; write 16'hBEEF with be = 2'b10 and read address 5 in the same cycle -> 16'h0000 for RDW_MODE = 0, 16'hBE00 for RDW_MODE = 1.
- Clear request: in IDLE, assert clr_req with a simultaneous write to address 2 -> busy high for 16 cycles. A wr_en during the sweep produces a wr_drop pulse and no write. All addresses read INIT_VAL afterwards.
- Reset mid-sweep and mid-read: assert rst_n = 0 at sweep cycle 7, or with a read in flight under OUT_REG = 1 -> outputs go to their reset values immediately, no rd_valid is issued, and a full 16-cycle sweep runs after release.
